// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers; one bit per cycle.
// Optional MD_ABORT_EN adds an abort input that cancels an in-flight mul/div.
//
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO write here
// S_ITER | one shift-add / restoring shift-subtract step per cycle
// S_FIX  | sign correction and HI/LO write-back
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MD_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [WIDTH-1:0]   ONE    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE2   = (2*WIDTH)'(1);
    localparam logic [CNT_W-1:0]   CNT_TC = CNT_W'(WIDTH-1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] wrk_q, wrk_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             is_div_q, is_div_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             b_zero_q, b_zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic             abort_w;
    logic             md_start;
    logic             signed_op;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [2*WIDTH-1:0] prod, prod_neg;

`ifdef MD_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Operand conditioning: signed ops iterate on magnitudes, signs restored in S_FIX.
    always_comb begin
        md_start  = start && (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU);
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        a_abs     = a_neg ? (~a + ONE) : a;
        b_abs     = b_neg ? (~b + ONE) : b;
    end

    always_comb begin
        mul_sum   = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_q, wrk_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opb_q};
        div_diff  = div_shift[WIDTH-1:0] - opb_q;
        prod      = {acc_q, wrk_q};
        prod_neg  = ~prod + ONE2;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        wrk_d    = wrk_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        b_zero_d = b_zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (md_start) begin
                    state_d  = S_ITER;
                    cnt_d    = '0;
                    acc_d    = '0;
                    wrk_d    = a_abs;
                    opb_d    = b_abs;
                    is_div_d = op[1];
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = a_neg;
                    b_zero_d = op[1] && (b == '0);
                end else if (start && op == OP_MTHI) begin
                    hi_d = a;
                end else if (start && op == OP_MTLO) begin
                    lo_d = a;
                end
            end
            S_ITER: begin
                if (is_div_q) begin
                    acc_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                    wrk_d = {wrk_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    wrk_d = {mul_sum[0], wrk_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_TC) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    lo_d = b_zero_q ? {WIDTH{1'b1}} : (neg_lo_q ? (~wrk_q + ONE) : wrk_q);
                    hi_d = neg_hi_q ? (~acc_q + ONE) : acc_q;
                end else begin
                    {hi_d, lo_d} = neg_lo_q ? prod_neg : prod;
                end
                done_d  = 1'b1;
                dbz_d   = is_div_q & b_zero_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A flush discards the partial result; HI/LO keep their pre-operation values.
        if (abort_w && state_q != S_IDLE) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
            dbz_d   = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            wrk_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            b_zero_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            wrk_q    <= wrk_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            b_zero_q <= b_zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO pushed at issue, popped at done.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b111;

    logic         clock = 1'b0;
    logic         reset, start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
`ifdef MD_ABORT_EN
    logic         abort;
`endif
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    exp_t sb_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
`ifdef MD_ABORT_EN
        .abort       (abort),
`endif
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clock = ~clock;

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t r;
        logic signed [2*W-1:0] sp;
        logic [2*W-1:0] up;
        logic [W-1:0] min_neg;
        min_neg = {1'b1, {(W-1){1'b0}}};
        r.dbz = 1'b0;
        r.hi  = '0;
        r.lo  = '0;
        if (o == OP_MULT) begin
            sp = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
            {r.hi, r.lo} = sp;
        end else if (o == OP_MULTU) begin
            up = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            {r.hi, r.lo} = up;
        end else if (y == '0) begin
            r.lo  = '1;
            r.hi  = x;
            r.dbz = 1'b1;
        end else if (o == OP_DIV && x == min_neg && y == '1) begin
            r.lo = min_neg;
            r.hi = '0;
        end else if (o == OP_DIV) begin
            r.lo = $signed(x) / $signed(y);
            r.hi = $signed(x) % $signed(y);
        end else begin
            r.lo = x / y;
            r.hi = x % y;
        end
        return r;
    endfunction

    // Start edge E0 is the first posedge after the call; returns 1 time unit after E0.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(posedge clock); #1;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clock); #1;
        start = 1'b0; op = OP_NOP;
    endtask

    // lat = edges after E0 until done seen (0 on timeout); busy_n counts busy samples from E0.
    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = busy ? 1 : 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clock); #1;
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_n++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset done: got %b want 0", done); else pass_cnt++;
        total_cnt++; if (div_by_zero !== 1'b0) $display("FAIL reset dbz: got %b want 0", div_by_zero); else pass_cnt++;
        total_cnt++; if (hi !== '0) $display("FAIL reset hi: got %h want 0", hi); else pass_cnt++;
        total_cnt++; if (lo !== '0) $display("FAIL reset lo: got %h want 0", lo); else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_mthi_mtlo();
        @(posedge clock); #1;
        start = 1'b1; op = OP_MTHI; a = 32'h12345678;
        @(posedge clock); #1;
        total_cnt++; if (hi !== 32'h12345678) $display("FAIL mthi hi: got %h want 12345678", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'h0) $display("FAIL mthi lo: got %h want 0", lo); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mthi busy/done: got %b/%b want 0/0", busy, done); else pass_cnt++;
        op = OP_MTLO; a = 32'h9ABCDEF0;
        @(posedge clock); #1;
        start = 1'b0; op = OP_NOP;
        total_cnt++; if (lo !== 32'h9ABCDEF0) $display("FAIL mtlo lo: got %h want 9abcdef0", lo); else pass_cnt++;
        total_cnt++; if (hi !== 32'h12345678) $display("FAIL mtlo hi: got %h want 12345678", hi); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mtlo busy/done: got %b/%b want 0/0", busy, done); else pass_cnt++;
    endtask

    task automatic test_mult();
        vec_t v[$];
        vec_t t;
        exp_t e;
        int lat, bn;
        t = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0}; v.push_back(t);
        t = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0}; v.push_back(t);
        t = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0}; v.push_back(t);
        foreach (v[i]) begin
            e.hi = v[i].hi; e.lo = v[i].lo; e.dbz = v[i].dbz;
            sb_q.push_back(e);
            issue(v[i].op, v[i].a, v[i].b);
            wait_done(lat, bn);
            total_cnt++; if (lat != 33) $display("FAIL mult[%0d] latency: got %0d want 33", i, lat); else pass_cnt++;
            total_cnt++; if (bn != 33 || busy !== 1'b0) $display("FAIL mult[%0d] busy: got %0d cycles, busy %b at done, want 33, 0", i, bn, busy); else pass_cnt++;
            if (sb_q.size() == 0) begin
                total_cnt++; $display("FAIL mult[%0d] scoreboard: got empty want entry", i);
            end else begin
                e = sb_q.pop_front();
                total_cnt++; if (hi !== e.hi) $display("FAIL mult[%0d] hi: got %h want %h", i, hi, e.hi); else pass_cnt++;
                total_cnt++; if (lo !== e.lo) $display("FAIL mult[%0d] lo: got %h want %h", i, lo, e.lo); else pass_cnt++;
                total_cnt++; if (div_by_zero !== e.dbz) $display("FAIL mult[%0d] dbz: got %b want %b", i, div_by_zero, e.dbz); else pass_cnt++;
            end
            @(posedge clock); #1;
            total_cnt++; if (done !== 1'b0) $display("FAIL mult[%0d] done pulse: got %b want 0", i, done); else pass_cnt++;
        end
    endtask

    task automatic test_div();
        vec_t v[$];
        vec_t t;
        exp_t e;
        int lat, bn;
        t = '{OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0}; v.push_back(t);
        t = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0}; v.push_back(t);
        t = '{OP_DIVU, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1}; v.push_back(t);
        t = '{OP_DIV,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1}; v.push_back(t);
        t = '{OP_DIVU, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 1'b0}; v.push_back(t);
        foreach (v[i]) begin
            e.hi = v[i].hi; e.lo = v[i].lo; e.dbz = v[i].dbz;
            sb_q.push_back(e);
            issue(v[i].op, v[i].a, v[i].b);
            wait_done(lat, bn);
            total_cnt++; if (lat != 33) $display("FAIL div[%0d] latency: got %0d want 33", i, lat); else pass_cnt++;
            if (sb_q.size() == 0) begin
                total_cnt++; $display("FAIL div[%0d] scoreboard: got empty want entry", i);
            end else begin
                e = sb_q.pop_front();
                total_cnt++; if (hi !== e.hi) $display("FAIL div[%0d] hi: got %h want %h", i, hi, e.hi); else pass_cnt++;
                total_cnt++; if (lo !== e.lo) $display("FAIL div[%0d] lo: got %h want %h", i, lo, e.lo); else pass_cnt++;
                total_cnt++; if (div_by_zero !== e.dbz) $display("FAIL div[%0d] dbz: got %b want %b", i, div_by_zero, e.dbz); else pass_cnt++;
            end
            @(posedge clock); #1;
            total_cnt++; if (done !== 1'b0 || div_by_zero !== 1'b0) $display("FAIL div[%0d] pulse: got done %b dbz %b want 0 0", i, done, div_by_zero); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int lat, bn, extra;
        e.hi = 32'd6; e.lo = 32'd142; e.dbz = 1'b0;
        sb_q.push_back(e);
        issue(OP_DIVU, 32'd1000, 32'd7);
        repeat (4) @(posedge clock);
        #1;
        start = 1'b1; op = OP_MULT; a = 32'd2; b = 32'd3;
        @(posedge clock); #1;
        start = 1'b0; op = OP_NOP;
        wait_done(lat, bn);
        total_cnt++; if (lat != 28) $display("FAIL b2b latency: got %0d want 28", lat); else pass_cnt++;
        if (sb_q.size() == 0) begin
            total_cnt++; $display("FAIL b2b scoreboard: got empty want entry");
        end else begin
            e = sb_q.pop_front();
            total_cnt++; if (hi !== e.hi) $display("FAIL b2b hi: got %h want %h", hi, e.hi); else pass_cnt++;
            total_cnt++; if (lo !== e.lo) $display("FAIL b2b lo: got %h want %h", lo, e.lo); else pass_cnt++;
        end
        extra = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clock); #1;
            if (done) extra++;
        end
        total_cnt++; if (extra != 0 || busy !== 1'b0) $display("FAIL b2b extra done: got %0d pulses busy %b want 0 0", extra, busy); else pass_cnt++;
        total_cnt++; if (lo !== 32'd142) $display("FAIL b2b lo held: got %h want 0000008e", lo); else pass_cnt++;
    endtask

    task automatic test_random();
        exp_t e;
        logic [2:0] o;
        logic [W-1:0] x, y;
        int lat, bn;
        for (int i = 0; i < 8; i++) begin
            o = 3'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            if (i % 2 == 1) y = y >> $urandom_range(0, 31);
            if (i == 5) y = '0;
            e = model(o, x, y);
            sb_q.push_back(e);
            issue(o, x, y);
            wait_done(lat, bn);
            total_cnt++; if (lat != 33) $display("FAIL rand[%0d] latency: got %0d want 33", i, lat); else pass_cnt++;
            if (sb_q.size() == 0) begin
                total_cnt++; $display("FAIL rand[%0d] scoreboard: got empty want entry", i);
            end else begin
                e = sb_q.pop_front();
                total_cnt++; if (hi !== e.hi || lo !== e.lo || div_by_zero !== e.dbz)
                    $display("FAIL rand[%0d] op %0d a %h b %h: got %h_%h dbz %b want %h_%h dbz %b", i, o, x, y, hi, lo, div_by_zero, e.hi, e.lo, e.dbz);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        issue(OP_MULT, 32'd5, 32'd9);
        repeat (9) @(posedge clock);
        #1;
        total_cnt++; if (busy !== 1'b1) $display("FAIL rst_mid busy before: got %b want 1", busy); else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (hi !== '0 || lo !== '0) $display("FAIL rst_mid hilo: got %h_%h want 0_0", hi, lo); else pass_cnt++;
        @(posedge clock); #1;
        reset = 1'b0;
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clock); #1;
            if (done || busy) cnt++;
        end
        total_cnt++; if (cnt != 0) $display("FAIL rst_mid done: got %0d active cycles want 0", cnt); else pass_cnt++;
    endtask

`ifdef MD_ABORT_EN
    task automatic test_abort();
        int cnt;
        issue(OP_MTHI, 32'hA5A5A5A5, 32'd0);
        issue(OP_MTLO, 32'h5A5A5A5A, 32'd0);
        issue(OP_DIV, 32'd100, 32'd3);
        repeat (4) @(posedge clock);
        #1;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL abort busy: got %b want 0", busy); else pass_cnt++;
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clock); #1;
            if (done || div_by_zero) cnt++;
        end
        total_cnt++; if (cnt != 0) $display("FAIL abort done: got %0d pulses want 0", cnt); else pass_cnt++;
        total_cnt++; if (hi !== 32'hA5A5A5A5 || lo !== 32'h5A5A5A5A) $display("FAIL abort hilo: got %h_%h want a5a5a5a5_5a5a5a5a", hi, lo); else pass_cnt++;
    endtask
`endif

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = OP_NOP;
        a     = '0;
        b     = '0;
`ifdef MD_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        test_mthi_mtlo();
        test_mult();
        test_div();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef MD_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
- Sits beside the combinational ALU in EX. Accepts one operation per start pulse and iterates one bit per cycle.
- Raises busy so the hazard unit stalls HI/LO readers and new mul/div issues.
- Generalises the single-cycle ALU datapath to WIDTH bits, signed/unsigned modes, and a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  issue request; sampled only in IDLE
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others NOP
- a  in  WIDTH  operand A: multiplicand, dividend, or MTHI/MTLO source
- b  in  WIDTH  operand B: multiplier or divisor
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when HI/LO are updated by a mul/div
- div_by_zero  out  1  one-cycle pulse coincident with done when a DIV/DIVU had b==0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- abort  in  1  present only with MD_ABORT_EN; cancels the in-flight operation

Behaviour:
- Reset (async): state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0, working registers=0.
- FSM states: IDLE, ITER, FIX.
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}, at edge E0:
  - latch operands; signed ops take absolute values and record result signs;
  - go to ITER, busy=1.
- ITER: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, at edges E1..E_WIDTH. Counter counts 0..WIDTH-1; at E_WIDTH go to FIX.
- FIX, at edge E_WIDTH+1:
  - apply sign correction and write hi/lo; go to IDLE;
  - busy=0, done=1 for exactly that one cycle.
  - busy is high for WIDTH+1 cycles; results are visible the cycle done is high.
- Multiply result: {hi,lo} = full 2*WIDTH-bit product.
  - MULT: two's-complement signed.
  - MULTU: unsigned.
- Divide result: lo=quotient, hi=remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (b==0):
  - still takes the full WIDTH+1 cycles;
  - lo = all ones, hi = a (unchanged dividend);
  - div_by_zero pulses with done.
- Signed overflow (DIV, a = most-negative value, b = -1): lo = most-negative value, hi = 0. No flag.
- MTHI/MTLO in IDLE with start=1: write hi or lo at E0. No busy, no done. The other register is unchanged.
- NOP op codes, or start=0: no effect.
- start while busy: ignored. Operands are not re-sampled and the in-flight operation is unaffected.
- hi/lo hold their previous values throughout ITER; they update only in FIX or on MTHI/MTLO.
- Reset asserted mid-operation: immediate return to reset values. No done pulse.

Optional Feature:
- Macro: MD_ABORT_EN.
- With the macro defined:
  - abort port exists;
  - abort=1 in ITER or FIX forces IDLE at the next edge;
  - busy=0 from that edge, no done or div_by_zero pulse, hi/lo keep their pre-operation values;
  - abort in IDLE is ignored; abort and start in the same IDLE cycle: start wins.
  - Used for exception/branch flush.
- Without the macro: no abort port; every accepted operation runs to completion.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> done 33 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064; div_by_zero=1 in the same cycle as done.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on back-to-back cycles -> hi/lo each updated one edge after issue, no busy or done. A new start (MULT 2*3) during a busy DIVU is ignored: only the DIVU result appears and done fires once.
- Reset asserted 10 cycles into a MULT -> hi=lo=0, busy=0 immediately, no done. With MD_ABORT_EN: abort on cycle 5 of a DIV -> busy falls next edge, hi/lo keep their prior values, no done.
